fpu_col_feeder: RTL and testbench



---
 rtl/fpu_col_feeder.sv | 127 ++++++++++++
 tb/tb_fpu_col_feeder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fpu_col_feeder.sv
// fpu_col_feeder: sliding 3-column window feeder for the 3x3 MAC array.
// Define FPU_FEEDER_ZERO_PAD_EN to zero-pad both stripe edges (one extra window each side).
module fpu_col_feeder #(
   parameter int COL_WIDTH = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_col [COL_WIDTH-1:0],
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic [7:0] col0 [COL_WIDTH-1:0],
   output logic [7:0] col1 [COL_WIDTH-1:0],
   output logic [7:0] col2 [COL_WIDTH-1:0]
);
`ifdef FPU_FEEDER_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   typedef logic [7:0] col_t [COL_WIDTH-1:0];
   typedef enum logic [1:0] {IDLE, FILL, RUN, TAIL} state_t;
   localparam col_t ZERO = '{default: 8'd0};

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   col_t       c0_q, c1_q, c2_q, c0_d, c1_d, c2_d;
   logic       ov_q, ov_d, ol_q, ol_d;
   logic       acc, con;

   assign in_ready  = !(ov_q && !out_ready) && state_q != TAIL;
   assign acc       = in_valid && in_ready;
   assign con       = ov_q && out_ready;
   assign out_valid = ov_q;
   assign out_last  = ol_q;
   assign col0      = c0_q;
   assign col1      = c1_q;
   assign col2      = c2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      ov_d    = ov_q && !con;
      ol_d    = ol_q;
      if (state_q == TAIL) begin
         if (ol_q && con) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            c0_d    = ZERO;
            c1_d    = ZERO;
            c2_d    = ZERO;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
         end else if (!ol_q && (!ov_q || out_ready)) begin
            c0_d = c1_q;
            c1_d = c2_q;
            c2_d = ZERO;
            ov_d = 1'b1;
            ol_d = 1'b1;
         end
      end else begin
         // the last window may be consumed in the same cycle a new stripe starts
         if (con && ol_q) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            c0_d    = ZERO;
            c1_d    = ZERO;
            c2_d    = ZERO;
            ol_d    = 1'b0;
         end
         if (acc) begin
            if (PAD && cnt_d == 2'd0) begin
               c0_d  = ZERO;
               c1_d  = ZERO;
               c2_d  = in_col;
               cnt_d = 2'd2;
            end else begin
               c0_d  = c1_d;
               c1_d  = c2_d;
               c2_d  = in_col;
               cnt_d = (cnt_d == 2'd3) ? 2'd3 : cnt_d + 2'd1;
            end
            if (cnt_d == 2'd3) begin
               ov_d    = 1'b1;
               ol_d    = !PAD && in_last;
               state_d = (PAD && in_last) ? TAIL : RUN;
            end else if (in_last && PAD) begin
               state_d = TAIL;
            end else if (in_last) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
               c0_d    = ZERO;
               c1_d    = ZERO;
               c2_d    = ZERO;
            end else begin
               state_d = FILL;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         c0_q    <= ZERO;
         c1_q    <= ZERO;
         c2_q    <= ZERO;
         ov_q    <= 1'b0;
         ol_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         ov_q    <= ov_d;
         ol_q    <= ol_d;
      end
   end
endmodule

// File: tb/tb_fpu_col_feeder.sv
// tb_fpu_col_feeder: directed checks of window priming, backpressure, stripe end and reset.
module tb_fpu_col_feeder;
   localparam int CW = 10;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic       in_ready, out_valid, out_last;
   logic [7:0] in_col [CW-1:0];
   logic [7:0] col0 [CW-1:0];
   logic [7:0] col1 [CW-1:0];
   logic [7:0] col2 [CW-1:0];
   int checks = 0, errors = 0;

   fpu_col_feeder #(.COL_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_col(in_col), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last),
      .col0(col0), .col1(col1), .col2(col2)
   );

   always #5 clk = ~clk;

   // a column's value, or EE when its pixels are not all equal
   function automatic logic [7:0] cv(input logic [7:0] c [CW]);
      cv = c[0];
      for (int i = 1; i < CW; i++) if (c[i] !== c[0]) cv = 8'hEE;
   endfunction

   task automatic expect_st(input string tag, input logic [23:0] w,
                            input logic ov, input logic ol, input logic ir);
      logic [26:0] obs, exp;
      obs = {cv(col0), cv(col1), cv(col2), out_valid, out_last, in_ready};
      exp = {w, ov, ol, ir};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed win=%h v/l/rdy=%b expected win=%h v/l/rdy=%b",
                tag, obs[26:3], obs[2:0], exp[26:3], exp[2:0]);
      end
   endtask

   task automatic push(input logic [7:0] v, input logic l);
      in_valid = 1'b1;
      in_col   = '{default: v};
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_col = '{default: 8'd0};
      #2;
      expect_st("reset", 24'h000000, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef FPU_FEEDER_ZERO_PAD_EN
      push(8'd5, 0);  expect_st("pad_c5", 24'h000005, 0, 0, 1);
      push(8'd6, 0);  expect_st("pad_w056", 24'h000506, 1, 0, 1);
      push(8'd9, 1);  expect_st("pad_w569", 24'h050609, 1, 0, 0);
      idle();         expect_st("pad_tail", 24'h060900, 1, 1, 0);
      idle();         expect_st("pad_idle", 24'h000000, 0, 0, 1);
      push(8'd3, 1);  expect_st("pad1_acc", 24'h000003, 0, 0, 0);
      idle();         expect_st("pad1_win", 24'h000300, 1, 1, 0);
      idle();         expect_st("pad1_idle", 24'h000000, 0, 0, 1);
      push(8'd1, 0);
      push(8'd2, 0);
      rst_n = 1'b0;
      #1;
      expect_st("pad_rst", 24'h000000, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      push(8'd1, 0);
      push(8'd2, 0);  expect_st("pad_rst_w012", 24'h000102, 1, 0, 1);
`else
      push(8'd1, 0);  expect_st("prime_c1", 24'h000001, 0, 0, 1);
      idle();         expect_st("hold_no_valid", 24'h000001, 0, 0, 1);
      push(8'd2, 0);  expect_st("prime_c2", 24'h000102, 0, 0, 1);
      push(8'd3, 0);  expect_st("prime_w123", 24'h010203, 1, 0, 1);
      push(8'd4, 1);  expect_st("prime_w234", 24'h020304, 1, 1, 1);
      push(8'd5, 0);  expect_st("restart_c5", 24'h000005, 0, 0, 1);
      push(8'd6, 0);  expect_st("restart_c6", 24'h000506, 0, 0, 1);
      push(8'd7, 1);  expect_st("restart_w567", 24'h050607, 1, 1, 1);
      idle();         expect_st("end_idle", 24'h000000, 0, 0, 1);
      push(8'd1, 0);
      push(8'd2, 0);
      push(8'd3, 0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_col    = '{default: 8'd4};
      in_last   = 1'b1;
      #1;
      expect_st("bp_enter", 24'h010203, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         idle();
         expect_st("bp_hold", 24'h010203, 1, 0, 0);
      end
      out_ready = 1'b1;
      #1;
      expect_st("bp_release", 24'h010203, 1, 0, 1);
      idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_st("bp_w234", 24'h020304, 1, 1, 1);
      idle();         expect_st("bp_idle", 24'h000000, 0, 0, 1);
      push(8'd7, 0);  expect_st("short_c7", 24'h000007, 0, 0, 1);
      push(8'd8, 1);  expect_st("short_end", 24'h000000, 0, 0, 1);
      idle();         expect_st("short_idle", 24'h000000, 0, 0, 1);
      push(8'd1, 0);
      push(8'd2, 0);
      rst_n = 1'b0;
      #1;
      expect_st("rst_mid", 24'h000000, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      push(8'd1, 0);
      push(8'd2, 0);
      push(8'd3, 0);  expect_st("rst_w123", 24'h010203, 1, 0, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
